btn_tick_front: RTL and testbench
=================================

Name: btn_tick_front

Overview:
- Input front end for the press/timeout logic. Conditions raw push-button inputs into clean signals and generates the periodic timeout tick.
- Per button, it synchronises the raw input, debounces it, and emits a one-cycle press pulse on each debounced rising edge.
- It also produces a prescaled enable tick. The tick phase restarts on every press, so the downstream inactivity counter always counts whole tick periods from the last press.
- Outputs press and enable feed the downstream timeout counter directly.

Parameters:
- N_BTN, 4: number of button inputs (1..16).
- DB_CYCLES, 16: consecutive clk cycles a synchronised input must differ from the debounced level before the debounced level changes (>=2).
- TICK_DIV, 50000000: clk cycles per enable tick (>=2).
- Counter widths are $clog2 of DB_CYCLES and TICK_DIV respectively.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst  in  1  asynchronous, active-low reset: 0 = reset asserted, 1 = run.
- btn_raw  in  N_BTN  raw asynchronous button levels, 1 = pressed.
- tick_en  in  1  1 = tick counter runs; 0 = tick counter holds and enable stays 0.
- btn_level  out  N_BTN  debounced button levels.
- press_vec  out  N_BTN  one-cycle pulse per button on a debounced 0->1 transition.
- press  out  1  OR of press_vec; drives the downstream press input.
- enable  out  1  one-cycle tick pulse; drives the downstream enable input.

Behaviour:
- Reset (rst=0, asynchronous)
  - Synchroniser flops, btn_level, press_vec, press and enable go to 0.
  - All debounce counters and the tick counter go to 0.
  - Outputs hold these values until the first clk edge after rst returns to 1.
- Synchroniser
  - Two flops per bit; sync[i] follows btn_raw[i] after 2 clk edges.
- Debounce, per bit
  - If sync[i] == btn_level[i], the counter clears to 0.
  - Otherwise the counter increments.
  - At the edge where the counter equals DB_CYCLES-1 and the mismatch persists, btn_level[i] takes sync[i] and the counter clears.
  - A single matching cycle during the count clears the counter (glitch rejected).
- Press pulse
  - press_vec[i] is registered.
  - It is 1 for exactly the cycle in which btn_level[i] has just changed 0->1; otherwise 0.
  - A release (1->0) produces no pulse.
  - Latency from a clean btn_raw rise to press_vec high is 2+DB_CYCLES edges.
- press
  - Registered OR of the same next-state terms, so it is cycle-aligned with press_vec.
  - Simultaneous presses on several buttons give one press pulse, with all corresponding press_vec bits set.
- Tick generator, evaluated each edge in priority order:
  - (1) press next-state = 1: tick counter <= 0, enable <= 0.
  - (2) tick_en = 0: tick counter holds, enable <= 0.
  - (3) tick counter == TICK_DIV-1: tick counter <= 0, enable <= 1.
  - (4) otherwise: tick counter increments, enable <= 0.
- Tick timing
  - The first enable comes TICK_DIV edges after reset release, or after the edge that raised press.
  - Period is TICK_DIV cycles; enable is never high in the same cycle as press.
- Button held through reset
  - btn_level starts at 0, so the held button debounces normally after reset release and produces one press.
- Reset asserted mid-debounce or mid-tick
  - State is discarded immediately; no pulse is generated by reset itself.
- Reset deassertion
  - Downstream logic must keep a synchronised rst release; this block does not resynchronise rst.

Test Plan:
Bench configuration: N_BTN=4, DB_CYCLES=4, TICK_DIV=5, tick_en=1 unless stated.
1. Reset, then btn_raw[0]=1 held from cycle 0 -> press_vec=4'b0001 and press=1 at edge 6 only; btn_level[0]=1 from edge 6; 0 again 6 edges after release; no pulse on release.
2. btn_raw[1] high for 3 cycles, low 1 cycle, high 3 cycles -> btn_level[1] stays 0; press never asserts.
3. btn_raw[2] and btn_raw[3] rise in the same cycle -> press_vec=4'b1100 for one cycle; press high for exactly one cycle.
4. No buttons after reset -> enable pulses at edges 5, 10, 15; each pulse is one cycle wide.
5. Press lands on the edge where the tick counter = 4 -> enable stays 0 that cycle; next enable exactly 5 edges after press; tick_en=0 for 3 cycles mid-count delays the next enable by 3.
6. rst driven 0 mid-debounce (counter=2) and mid-tick -> all outputs 0 immediately; after release, a clean press again takes the full 6 edges.

Source files
------------

// File: rtl/btn_tick_front_if.sv
// Button front-end signal bundle: raw inputs and tick gate in, conditioned levels and pulses out.
interface btn_tick_front_if #(
  parameter int unsigned N_BTN = 4
);
  logic [N_BTN-1:0] btn_raw;
  logic             tick_en;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] press_vec;
  logic             press;
  logic             enable;

  modport master (
    output btn_raw, tick_en,
    input  btn_level, press_vec, press, enable
  );

  modport slave (
    input  btn_raw, tick_en,
    output btn_level, press_vec, press, enable
  );
endinterface

// File: rtl/btn_tick_front.sv
// Push-button conditioning (sync, debounce, press pulse) plus a prescaled timeout tick
// whose phase restarts on every press.
module btn_tick_front #(
  parameter int unsigned N_BTN     = 4,
  parameter int unsigned DB_CYCLES = 16,
  parameter int unsigned TICK_DIV  = 50000000
) (
  input  logic            clk,
  input  logic            rst,
  btn_tick_front_if.slave bus
);

  localparam int unsigned   DBW    = $clog2(DB_CYCLES);
  localparam int unsigned   TKW    = $clog2(TICK_DIV);
  localparam logic [DBW-1:0] DB_MAX = DBW'(DB_CYCLES - 1);
  localparam logic [TKW-1:0] TK_MAX = TKW'(TICK_DIV - 1);

  logic [N_BTN-1:0]           r_sync1;
  logic [N_BTN-1:0]           r_sync2;
  logic [N_BTN-1:0]           r_level;
  logic [N_BTN-1:0]           r_press_vec;
  logic                       r_press;
  logic                       r_enable;
  logic [N_BTN-1:0][DBW-1:0]  r_db_cnt;
  logic [TKW-1:0]             r_tick_cnt;

  logic [N_BTN-1:0]           w_level_nxt;
  logic [N_BTN-1:0]           w_press_vec_nxt;
  logic                       w_press_nxt;
  logic [N_BTN-1:0][DBW-1:0]  w_db_cnt_nxt;
  logic [TKW-1:0]             w_tick_cnt_nxt;
  logic                       w_enable_nxt;

  // Debounce: a level change needs DB_CYCLES consecutive mismatching samples.
  always_comb begin
    w_level_nxt  = r_level;
    w_db_cnt_nxt = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      if (r_sync2[i] == r_level[i]) begin
        w_db_cnt_nxt[i] = '0;
      end else if (r_db_cnt[i] == DB_MAX) begin
        w_level_nxt[i]  = r_sync2[i];
        w_db_cnt_nxt[i] = '0;
      end else begin
        w_db_cnt_nxt[i] = r_db_cnt[i] + 1'b1;
      end
    end
    w_press_vec_nxt = w_level_nxt & ~r_level;
    w_press_nxt     = |w_press_vec_nxt;
  end

  // Tick priority: press restarts the phase, then gate, then wrap, then count.
  always_comb begin
    w_tick_cnt_nxt = r_tick_cnt;
    w_enable_nxt   = 1'b0;
    if (w_press_nxt) begin
      w_tick_cnt_nxt = '0;
    end else if (!bus.tick_en) begin
      w_tick_cnt_nxt = r_tick_cnt;
    end else if (r_tick_cnt == TK_MAX) begin
      w_tick_cnt_nxt = '0;
      w_enable_nxt   = 1'b1;
    end else begin
      w_tick_cnt_nxt = r_tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_level     <= '0;
      r_press_vec <= '0;
      r_press     <= 1'b0;
      r_enable    <= 1'b0;
      r_db_cnt    <= '0;
      r_tick_cnt  <= '0;
    end else begin
      r_sync1     <= bus.btn_raw;
      r_sync2     <= r_sync1;
      r_level     <= w_level_nxt;
      r_press_vec <= w_press_vec_nxt;
      r_press     <= w_press_nxt;
      r_enable    <= w_enable_nxt;
      r_db_cnt    <= w_db_cnt_nxt;
      r_tick_cnt  <= w_tick_cnt_nxt;
    end
  end

  assign bus.btn_level = r_level;
  assign bus.press_vec = r_press_vec;
  assign bus.press     = r_press;
  assign bus.enable    = r_enable;

endmodule

// File: tb/tb_btn_tick_front.sv
// Scoreboard bench for btn_tick_front: expected outputs per edge are queued with the stimulus
// and compared as each edge's outputs settle.
module tb_btn_tick_front;

  localparam int unsigned N_BTN = 4;

  typedef struct {
    int unsigned cyc;
    string       tag;
    int          sel;   // 0 btn_level, 1 press_vec, 2 press, 3 enable
    logic [7:0]  val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  exp_t        sb[$];

  btn_tick_front_if #(.N_BTN(N_BTN)) u_if ();

  btn_tick_front #(
    .N_BTN     (N_BTN),
    .DB_CYCLES (4),
    .TICK_DIV  (5)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [7:0] obs_of(input int sel);
    case (sel)
      0:       obs_of = {4'b0, u_if.btn_level};
      1:       obs_of = {4'b0, u_if.press_vec};
      2:       obs_of = {7'b0, u_if.press};
      default: obs_of = {7'b0, u_if.enable};
    endcase
  endfunction

  task automatic push(input int unsigned c, input string tag, input int sel, input logic [7:0] v);
    sb.push_back('{c, tag, sel, v});
  endtask

  task automatic drain();
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        chk(sb[i].tag, {24'b0, obs_of(sb[i].sel)}, {24'b0, sb[i].val});
        sb.delete(i);
      end
    end
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned j = 0; j < n; j++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      drain();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_lvl"}, {28'b0, u_if.btn_level}, 32'h0);
    chk({tag, "_pv"},  {28'b0, u_if.press_vec}, 32'h0);
    chk({tag, "_prs"}, {31'b0, u_if.press},     32'h0);
    chk({tag, "_en"},  {31'b0, u_if.enable},    32'h0);
  endtask

  task automatic reset_dut(input string tag);
    rst = 1'b0;
    u_if.btn_raw = '0;
    u_if.tick_en = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero(tag);
    rst = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    u_if.btn_raw = '0;
    u_if.tick_en = 1'b1;

    // 1: held press, release, tick restart on press
    reset_dut("t1_rst");
    u_if.btn_raw = 4'b0001;
    for (int unsigned k = 1; k <= 20; k++) begin
      push(k, "t1_press", 2, (k == 6) ? 8'h01 : 8'h00);
      push(k, "t1_pv",    1, (k == 6) ? 8'h01 : 8'h00);
      push(k, "t1_lvl",   0, (k >= 6 && k <= 15) ? 8'h01 : 8'h00);
      push(k, "t1_en",    3, (k == 5 || k == 11 || k == 16) ? 8'h01 : 8'h00);
    end
    run(10);
    u_if.btn_raw = 4'b0000;
    run(10);
    chk("t1_sb_empty", sb.size(), 0);

    // 2: glitchy input never debounces
    reset_dut("t2_rst");
    for (int unsigned k = 1; k <= 15; k++) begin
      push(k, "t2_lvl",   0, 8'h00);
      push(k, "t2_press", 2, 8'h00);
    end
    u_if.btn_raw = 4'b0010;
    run(3);
    u_if.btn_raw = 4'b0000;
    run(1);
    u_if.btn_raw = 4'b0010;
    run(3);
    u_if.btn_raw = 4'b0000;
    run(8);
    chk("t2_sb_empty", sb.size(), 0);

    // 3: simultaneous presses
    reset_dut("t3_rst");
    u_if.btn_raw = 4'b1100;
    for (int unsigned k = 1; k <= 10; k++) begin
      push(k, "t3_pv",    1, (k == 6) ? 8'h0C : 8'h00);
      push(k, "t3_press", 2, (k == 6) ? 8'h01 : 8'h00);
      push(k, "t3_lvl",   0, (k >= 6) ? 8'h0C : 8'h00);
    end
    run(10);
    chk("t3_sb_empty", sb.size(), 0);

    // 4: free-running tick
    reset_dut("t4_rst");
    for (int unsigned k = 1; k <= 16; k++)
      push(k, "t4_en", 3, (k % 5 == 0) ? 8'h01 : 8'h00);
    run(16);
    chk("t4_sb_empty", sb.size(), 0);

    // 5: press on wrap edge, then tick_en gap
    reset_dut("t5_rst");
    for (int unsigned k = 1; k <= 25; k++) begin
      push(k, "t5_en",    3, (k == 5 || k == 15 || k == 23) ? 8'h01 : 8'h00);
      push(k, "t5_press", 2, (k == 10) ? 8'h01 : 8'h00);
    end
    run(4);
    u_if.btn_raw = 4'b0001;
    run(12);
    u_if.tick_en = 1'b0;
    run(3);
    u_if.tick_en = 1'b1;
    run(6);
    chk("t5_sb_empty", sb.size(), 0);

    // 6: reset mid-debounce and on an enable cycle
    reset_dut("t6_rst");
    u_if.btn_raw = 4'b0001;
    push(5, "t6_en_pre", 3, 8'h01);
    push(5, "t6_lvl_pre", 0, 8'h00);
    run(1);
    u_if.btn_raw = 4'b0011;
    run(4);
    rst = 1'b0;
    #1;
    chk_all_zero("t6_async");
    repeat (2) @(negedge clk);
    chk_all_zero("t6_hold");
    rst = 1'b1;
    cyc = 0;
    for (int unsigned k = 1; k <= 8; k++) begin
      push(k, "t6_press", 2, (k == 6) ? 8'h01 : 8'h00);
      push(k, "t6_pv",    1, (k == 6) ? 8'h03 : 8'h00);
      push(k, "t6_lvl",   0, (k >= 6) ? 8'h03 : 8'h00);
    end
    run(8);
    chk("t6_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
